// File: rtl/cpu16_seq.sv
`timescale 1ns/1ps
// cpu16_seq: multi-cycle instruction sequencer for the cpu16 datapath.
// Owns PC and IR, fetches over a request/ready handshake, validates the
// decoder's one-hot ICNT, gates the register-file write and counts
// retired instructions.
//
// Ports:
//   CK      in   clock, all state changes on posedge
//   RST     in   asynchronous active-high reset
//   RUN     in   enable, sampled in IDLE and at the end of WB
//   MREQ    out  instruction-fetch request (high in FETCH)
//   MADDR   out  fetch address, always even
//   MRDY    in   memory ready; MDATA valid when MREQ & MRDY
//   MDATA   in   instruction word
//   IR      out  instruction register, to decoder
//   ICNT    in   one-hot op select from decoder (ADD, SUB, AND, OR)
//   RF_WE   out  register-file write enable, one cycle in WB
//   PC      out  address of next instruction to fetch
//   RETIRED out  count of instructions written back (wraps)
//   BUSY    out  high in FETCH, DECODE, EXEC, WB
//   HALTED  out  high in HALT
//   ILLEGAL out  sticky flag, set when a bad ICNT is decoded
module cpu16_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] HALT_OP  = 16'hFFFF
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        RUN,
  output logic        MREQ,
  output logic [15:0] MADDR,
  input  logic        MRDY,
  input  logic [15:0] MDATA,
  output logic [15:0] IR,
  input  logic [3:0]  ICNT,
  output logic        RF_WE,
  output logic [15:0] PC,
  output logic [15:0] RETIRED,
  output logic        BUSY,
  output logic        HALTED,
  output logic        ILLEGAL
);

  localparam logic [15:0] PcInit = RESET_PC & 16'hFFFE;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        icnt_ok;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    // Exact one-hot match: zero, multi-hot and unknown values all fail.
    icnt_ok   = (ICNT == 4'b0001) || (ICNT == 4'b0010) ||
                (ICNT == 4'b0100) || (ICNT == 4'b1000);

    unique case (state_q)
      StIdle: begin
        if (RUN) state_d = StFetch;
      end
      StFetch: begin
        if (MRDY) begin
          ir_d    = MDATA;
          pc_d    = pc_q + 16'd2;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (ir_q == HALT_OP) begin
          state_d = StHalt;
        end else if (icnt_ok) begin
          state_d = StExec;
        end else begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end
      end
      StExec: begin
        state_d = StWb;
      end
      StWb: begin
        retired_d = retired_q + 16'd1;
        state_d   = RUN ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      pc_q      <= PcInit;
      ir_q      <= 16'h0000;
      retired_q <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs depend on registered state only, so reset drops them at once.
  assign MREQ    = (state_q == StFetch);
  assign RF_WE   = (state_q == StWb);
  assign BUSY    = (state_q == StFetch) || (state_q == StDecode) ||
                   (state_q == StExec)  || (state_q == StWb);
  assign HALTED  = (state_q == StHalt);
  assign MADDR   = {pc_q[15:1], 1'b0};
  assign PC      = pc_q;
  assign IR      = ir_q;
  assign RETIRED = retired_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_cpu16_seq.sv
`timescale 1ns/1ps
module tb_cpu16_seq;

  logic        CK   = 1'b0;
  logic        RST  = 1'b1;
  logic        RUN  = 1'b0;
  logic        MRDY = 1'b0;
  logic [15:0] MDATA;
  logic [3:0]  ICNT;
  logic        MREQ, RF_WE, BUSY, HALTED, ILLEGAL;
  logic [15:0] MADDR, IR, PC, RETIRED;

  // Second instance exercising PC wrap from RESET_PC = 16'hFFFE.
  logic        w_mreq, w_rf_we, w_busy, w_halted, w_illegal;
  logic [15:0] w_maddr, w_ir, w_pc, w_retired;

  logic [15:0] mem [256];
  logic [15:0] rf [16];
  logic [15:0] rf_init [16];
  logic        force_en = 1'b0;
  logic [3:0]  force_val = 4'b0000;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CK = ~CK;

  // Decoder stand-in: opcode nibble IR[7:4] selects the op, dest IR[11:8], src IR[3:0].
  function automatic logic [3:0] decode(input logic [15:0] ir);
    case (ir[7:4])
      4'hA:    return 4'b0001;
      4'hB:    return 4'b0010;
      4'hC:    return 4'b0100;
      4'hD:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] alu_icnt(input logic [3:0] icnt, input logic [15:0] a,
                                           input logic [15:0] b);
    case (icnt)
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0100: return a & b;
      4'b1000: return a | b;
      default: return a;
    endcase
  endfunction

  // Reference op semantics by opcode index (0 ADD, 1 SUB, 2 AND, 3 OR).
  function automatic logic [15:0] model_op(input int op, input logic [15:0] a,
                                           input logic [15:0] b);
    if (op == 0) return a + b;
    if (op == 1) return a - b;
    if (op == 2) return a & b;
    return a | b;
  endfunction

  assign MDATA = mem[MADDR[8:1]];
  assign ICNT  = force_en ? force_val : decode(IR);

  always @(posedge CK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
    end else if (RF_WE) begin
      rf[IR[11:8]] <= alu_icnt(ICNT, rf[IR[11:8]], rf[IR[3:0]]);
    end
  end

  cpu16_seq u_dut (
    .CK      (CK),
    .RST     (RST),
    .RUN     (RUN),
    .MREQ    (MREQ),
    .MADDR   (MADDR),
    .MRDY    (MRDY),
    .MDATA   (MDATA),
    .IR      (IR),
    .ICNT    (ICNT),
    .RF_WE   (RF_WE),
    .PC      (PC),
    .RETIRED (RETIRED),
    .BUSY    (BUSY),
    .HALTED  (HALTED),
    .ILLEGAL (ILLEGAL)
  );

  cpu16_seq #(.RESET_PC(16'hFFFE)) u_wrap (
    .CK      (CK),
    .RST     (RST),
    .RUN     (RUN),
    .MREQ    (w_mreq),
    .MADDR   (w_maddr),
    .MRDY    (1'b1),
    .MDATA   (16'h00A1),
    .IR      (w_ir),
    .ICNT    (4'b0001),
    .RF_WE   (w_rf_we),
    .PC      (w_pc),
    .RETIRED (w_retired),
    .BUSY    (w_busy),
    .HALTED  (w_halted),
    .ILLEGAL (w_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {27'd0, MREQ, RF_WE, BUSY, HALTED, ILLEGAL}, 32'd0);
    check({tag, "_pc"}, {16'd0, PC}, 32'd0);
    check({tag, "_maddr"}, {16'd0, MADDR}, 32'd0);
    check({tag, "_ir"}, {16'd0, IR}, 32'd0);
    check({tag, "_retired"}, {16'd0, RETIRED}, 32'd0);
  endtask

  // Reset for one full cycle, release with RUN=1; the next posedge enters FETCH (cycle 1).
  task automatic start();
    @(negedge CK);
    RST = 1'b1; RUN = 1'b0; MRDY = 1'b0;
    @(negedge CK);
    RST = 1'b0; RUN = 1'b1;
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  typedef struct {
    logic [15:0] w0, w1, w2;
    logic        fen;
    logic [3:0]  fval;
    int          waits;
    int          ncyc;
    logic [31:0] we_mask, mreq_mask;
    logic [15:0] retired, pc, r0;
    logic        halted, illegal;
  } vec_t;

  vec_t vt [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waitcnt, fidx, bad;
    logic [31:0] we_m, mreq_m;
    logic [15:0] prev_ir;
    logic prev_hs;

    for (int i = 0; i < 16; i++) rf_init[i] = (i < 4) ? 16'(10 + i) : 16'h0000;
    clear_mem();

    // {w0, w1, w2, force, forced ICNT, waits, cycles, RF_WE mask, MREQ mask,
    //  RETIRED, PC, R0, HALTED, ILLEGAL}
    vt[0] = '{16'h00A1, 16'h00A2, 16'h00A3, 1'b0, 4'h0, 0, 12, 32'h1110, 32'h0222,
              16'd3, 16'd6, 16'd46, 1'b0, 1'b0};
    vt[1] = '{16'h00A1, 16'hFFFF, 16'h0000, 1'b0, 4'h0, 0, 10, 32'h0010, 32'h0022,
              16'd1, 16'd4, 16'd21, 1'b1, 1'b0};
    vt[2] = '{16'h0051, 16'h00A1, 16'h0000, 1'b0, 4'h0, 0, 6, 32'h0000, 32'h0002,
              16'd0, 16'd2, 16'd10, 1'b1, 1'b1};
    vt[3] = '{16'h00A1, 16'h00A2, 16'h0000, 1'b1, 4'b0011, 0, 6, 32'h0000, 32'h0002,
              16'd0, 16'd2, 16'd10, 1'b1, 1'b1};
    vt[4] = '{16'h00A1, 16'h00A2, 16'h0000, 1'b0, 4'h0, 3, 14, 32'h4080, 32'h0F1E,
              16'd2, 16'd4, 16'd33, 1'b0, 1'b0};

    // Reset state (RST has been high since time 0).
    @(negedge CK);
    check_reset_outputs("reset");

    for (int v = 0; v < 5; v++) begin
      clear_mem();
      mem[0] = vt[v].w0; mem[1] = vt[v].w1; mem[2] = vt[v].w2;
      force_en = vt[v].fen; force_val = vt[v].fval;
      start();
      waitcnt = 0; fidx = 0; bad = 0; we_m = 0; mreq_m = 0;
      prev_ir = IR; prev_hs = 1'b0;
      for (int c = 1; c <= vt[v].ncyc; c++) begin
        step();
        if (IR !== prev_ir && !prev_hs) bad++;
        if (MREQ && MADDR !== 16'(2 * fidx)) bad++;
        if (RF_WE) we_m[c] = 1'b1;
        if (MREQ) mreq_m[c] = 1'b1;
        prev_ir = IR; prev_hs = 1'b0;
        if (MREQ) begin
          if (waitcnt < vt[v].waits) begin
            MRDY = 1'b0; waitcnt++;
          end else begin
            MRDY = 1'b1; waitcnt = 0; prev_hs = 1'b1; fidx++;
          end
        end else begin
          MRDY = 1'b0;
        end
      end
      step();
      check($sformatf("v%0d_rf_we_cycles", v), we_m, vt[v].we_mask);
      check($sformatf("v%0d_mreq_cycles", v), mreq_m, vt[v].mreq_mask);
      check($sformatf("v%0d_retired", v), {16'd0, RETIRED}, {16'd0, vt[v].retired});
      check($sformatf("v%0d_pc", v), {16'd0, PC}, {16'd0, vt[v].pc});
      check($sformatf("v%0d_r0", v), {16'd0, rf[0]}, {16'd0, vt[v].r0});
      check($sformatf("v%0d_halted", v), {31'd0, HALTED}, {31'd0, vt[v].halted});
      check($sformatf("v%0d_illegal", v), {31'd0, ILLEGAL}, {31'd0, vt[v].illegal});
      check($sformatf("v%0d_ir_maddr_stable", v), bad, 0);
      force_en = 1'b0;
    end

    // PC wrap: instance reset to 16'hFFFE fetches there, then at 0x0000.
    start();
    step();
    check("wrap_first_fetch", {15'd0, w_mreq, w_maddr}, {15'd0, 1'b1, 16'hFFFE});
    step();
    check("wrap_pc_after_fetch", {16'd0, w_pc}, 32'h0000);
    check("wrap_ir", {16'd0, w_ir}, 32'h00A1);
    step(); step();
    check("wrap_wb", {29'd0, w_rf_we, w_busy, w_halted | w_illegal}, 32'b110);
    step();
    check("wrap_second_fetch", {15'd0, w_mreq, w_maddr}, {15'd0, 1'b1, 16'h0000});
    check("wrap_retired", {16'd0, w_retired}, 32'd1);

    // RUN dropped during EXEC: instruction completes, then IDLE, then resume.
    clear_mem();
    mem[0] = 16'h00A1; mem[1] = 16'h00A2;
    start();
    MRDY = 1'b1;
    step(); step(); step();
    RUN = 1'b0;
    step();
    check("rundrop_wb", {31'd0, RF_WE}, 32'd1);
    step();
    check("rundrop_idle", {29'd0, BUSY, MREQ, RF_WE}, 32'd0);
    check("rundrop_state", {RETIRED, PC}, {16'd1, 16'd2});
    step();
    check("rundrop_still_idle", {31'd0, BUSY}, 32'd0);
    RUN = 1'b1;
    step();
    check("rundrop_resume", {15'd0, MREQ, MADDR}, {15'd0, 1'b1, 16'd2});

    // Async reset mid-FETCH.
    start();
    MRDY = 1'b0;
    step();
    check("areset_fetch_pre", {31'd0, MREQ}, 32'd1);
    RST = 1'b1;
    #1;
    check("areset_fetch_drop", {30'd0, MREQ, BUSY}, 32'd0);

    // Async reset mid-WB, after a real instruction loaded IR.
    start();
    MRDY = 1'b1;
    step(); step(); step(); step();
    check("areset_wb_pre", {31'd0, RF_WE}, 32'd1);
    RST = 1'b1;
    #1;
    check("areset_wb_drop", {31'd0, RF_WE}, 32'd0);
    check_reset_outputs("areset_wb");
    start();
    step();
    check("areset_restart", {15'd0, MREQ, MADDR}, {15'd0, 1'b1, 16'd0});

    // Randomized programs with random wait states against a transaction-level model.
    for (int t = 0; t < 4; t++) begin
      int n, s, c, widx, halt_cyc, exp_halt, op, d, sr, rbad;
      int w [9];
      int wb [8];
      logic [15:0] erf [16];
      clear_mem();
      n = $urandom_range(3, 8);
      for (int i = 0; i < 16; i++) begin
        rf_init[i] = 16'($urandom);
        erf[i] = rf_init[i];
      end
      for (int k = 0; k < n; k++) begin
        op = $urandom_range(0, 3); d = $urandom_range(0, 15); sr = $urandom_range(0, 15);
        mem[k] = {4'h0, d[3:0], 4'hA + op[3:0], sr[3:0]};
        erf[d] = model_op(op, erf[d], erf[sr]);
      end
      mem[n] = 16'hFFFF;
      for (int k = 0; k <= n; k++) w[k] = $urandom_range(0, 3);
      s = 1;
      for (int k = 0; k < n; k++) begin
        wb[k] = s + w[k] + 3;
        s += 4 + w[k];
      end
      exp_halt = s + w[n] + 2;

      start();
      c = 0; widx = 0; fidx = 0; waitcnt = 0; bad = 0; halt_cyc = 0;
      while (!HALTED && c < 400) begin
        step();
        c++;
        if (RF_WE) begin
          if (widx >= n || wb[widx] != c) bad++;
          widx++;
        end
        if (MREQ && MADDR !== 16'(2 * fidx)) bad++;
        if (MREQ && fidx <= n) begin
          if (waitcnt < w[fidx]) begin
            MRDY = 1'b0; waitcnt++;
          end else begin
            MRDY = 1'b1; waitcnt = 0; fidx++;
          end
        end else begin
          MRDY = 1'b0;
        end
        if (HALTED) halt_cyc = c;
      end
      rbad = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== erf[i]) rbad++;
      check($sformatf("rand%0d_halt_cycle", t), halt_cyc, exp_halt);
      check($sformatf("rand%0d_wb_count", t), widx, n);
      check($sformatf("rand%0d_sequence", t), bad, 0);
      check($sformatf("rand%0d_retired", t), {16'd0, RETIRED}, 32'(n));
      check($sformatf("rand%0d_pc", t), {16'd0, PC}, 32'(2 * (n + 1)));
      check($sformatf("rand%0d_illegal", t), {31'd0, ILLEGAL}, 32'd0);
      check($sformatf("rand%0d_regfile", t), rbad, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
